ysyx_25040111_axi_mem_resp: RTL and testbench
=============================================

YSYX_25040111_AXI_MEM_RESP -- requirements
Module: ysyx_25040111_axi_mem_resp

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: first byte address served.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit storage words, power of two.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have AR ports: arvalid in 1, arready out 1, araddr in 32, arid in 4, arlen in 8, arsize in 3, arburst in 2.
REQ-006 SHALL have R ports: rvalid out 1, rready in 1, rdata out 32, rresp out 2, rlast out 1, rid out 4.
REQ-007 SHALL have AW ports: awvalid in 1, awready out 1, awaddr in 32, awid in 4, awlen in 8, awsize in 3, awburst in 2.
REQ-008 SHALL have W ports: wvalid in 1, wready out 1, wdata in 32, wstrb in 4, wlast in 1.
REQ-009 SHALL have B ports: bvalid out 1, bready in 1, bresp out 2, bid out 4.

Function
REQ-010 SHALL act as AXI4 subordinate; read and write paths are independent FSMs that run concurrently.
REQ-011 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; arready=1 only in R_IDLE.
REQ-012 On AR handshake SHALL latch address, id, len, burst and go R_IDLE->R_WAIT; R_WAIT->R_DATA when delay counter is 0.
REQ-013 In R_DATA rvalid=1 and rdata/rresp/rlast/rid SHALL stay stable until rready; rlast=1 on beat arlen+1 only.
REQ-014 On R handshake with beats remaining SHALL advance address (INCR: +4, FIXED: unchanged) and return to R_WAIT; on last beat go R_IDLE.
REQ-015 Write FSM SHALL have states W_IDLE, W_DATA, W_WAIT, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA.
REQ-016 Each W handshake SHALL update only byte lanes with wstrb bit set at the word of the current address, then advance address as REQ-014.
REQ-017 W_DATA->W_WAIT on W handshake with wlast=1; W_WAIT->W_RESP when delay counter is 0; bvalid=1 in W_RESP until bready, then W_IDLE.
REQ-018 rid SHALL echo latched arid; bid SHALL echo latched awid.
REQ-019 Word index SHALL be (addr-BASE_ADDR)>>2; address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL give resp 2'b10 (SLVERR), rdata 0, no storage update.
REQ-020 arburst/awburst 2'b10 (WRAP) or 2'b11 SHALL give SLVERR on every beat and no storage update; any beat error makes bresp SLVERR.
REQ-021 wlast mismatch with awlen count (early or missing) SHALL set bresp SLVERR; transfer ends on the beat with wlast=1.
REQ-022 rdata SHALL be the full aligned word; lane selection is the initiator's responsibility; arsize/awsize are ignored beyond legality.
REQ-023 Same-cycle W handshake and R read of same word: read SHALL return the old word (write visible next cycle).
REQ-024 Without delay feature, rvalid SHALL rise the cycle after AR handshake and bvalid the cycle after last W handshake.

Reset
REQ-025 On rst=1 both FSMs SHALL go idle; arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rresp=0, bresp=0, rdata=0, rid=0, bid=0.
REQ-026 Reset mid-burst SHALL abort the transfer with no further beats or response; storage contents SHALL NOT be cleared.

Configuration
REQ-027 Macro YSYX_25040111_AXI_DELAY_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) SHALL load delay counter with lfsr[2:0] on entry to R_WAIT/W_WAIT, giving 0-7 extra cycles per beat/response.
REQ-028 Macro undefined: delay counter SHALL be constant 0 and LFSR absent.

Verification
REQ-029 Write awaddr 8000_0010, awlen 0, wdata DEADBEEF, wstrb 1111 -> bvalid next cycle, bresp 00; read same addr -> rdata DEADBEEF, rlast 1, rresp 00.
REQ-030 wstrb 0010, wdata 0000_5500 to 8000_0010 after REQ-029 -> readback DEAD55EF.
REQ-031 INCR read arlen 3 from 8000_0000, rready held 0 for 2 cycles on beat 1 -> 4 beats, data stable while stalled, rlast only on beat 4, rid=arid.
REQ-032 Read araddr 7FFF_FFFC and write awburst 10 -> rresp 10, rdata 0; bresp 10, storage unchanged.
REQ-033 Simultaneous AR and AW handshake to the same word -> both complete; read returns old word; later read returns new.
REQ-034 rst asserted during beat 2 of 4-beat write -> bvalid never asserted, awready=1 next cycle; with DELAY_EN, rvalid latency per beat within 1-8 cycles.

Source files
------------

// File: rtl/ysyx_25040111_axi_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25040111_axi_mem_resp
//  Brief    : AXI4 subordinate backed by a word-organised RAM. The read and
//             write channels are served by two independent FSMs that run
//             concurrently. Out-of-range addresses and WRAP/reserved bursts
//             return SLVERR. A write-response error is also raised when wlast
//             does not line up with awlen.
//  Options  : YSYX_25040111_AXI_DELAY_EN - an 8-bit LFSR inserts 0-7 extra
//             wait cycles before every read beat and every write response.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_axi_mem_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    // read address
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    // read data
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid,
    // write address
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    // write data
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    // write response
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES  = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA}         rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_e;

    // An address below BASE_ADDR wraps to >= 2^32 in 33 bits, so a single
    // compare covers both ends of the window.
    function automatic logic addr_ok(input logic [31:0] a);
        return ({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + 32'd4;
    endfunction

    // Transfer sizes are not used: the full word is always returned/addressed.
    logic unused_ok;
    assign unused_ok = ^{arsize, awsize};

    // ------------------------------------------------------------------------
    // Wait-state source
    // ------------------------------------------------------------------------
    logic [2:0] delay_w;
`ifdef YSYX_25040111_AXI_DELAY_EN
    logic [7:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps for x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign delay_w = lfsr_q[2:0];
`else
    assign delay_w = 3'd0;
`endif

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    rd_state_e   rstate_q;
    logic [31:0] raddr_q;
    logic [7:0]  rlen_q;
    logic [7:0]  rbeat_q;
    logic [1:0]  rburst_q;
    logic [2:0]  rcnt_q;
    logic        arready_q, rvalid_q, rlast_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;

    logic [31:0] rfetch_addr;
    logic [1:0]  rfetch_burst;
    logic        rfetch_last;
    logic        rfetch_err;
    logic [31:0] rfetch_data;

    // Select the beat that is about to be presented: the new request from
    // idle, the following beat when a handshake completes, or the pending
    // beat at the end of a wait period.
    always_comb begin
        rfetch_addr  = raddr_q;
        rfetch_burst = rburst_q;
        rfetch_last  = (rbeat_q == rlen_q);
        if (rstate_q == R_IDLE) begin
            rfetch_addr  = araddr;
            rfetch_burst = arburst;
            rfetch_last  = (arlen == 8'd0);
        end else if (rstate_q == R_DATA) begin
            rfetch_addr  = next_addr(raddr_q, rburst_q);
            rfetch_last  = ((rbeat_q + 8'd1) == rlen_q);
        end
        rfetch_err  = rfetch_burst[1] | ~addr_ok(rfetch_addr);
        rfetch_data = rfetch_err ? 32'd0 : mem_q[word_idx(rfetch_addr)];
    end

    // Read FSM with registered channel outputs; a zero wait skips R_WAIT so
    // the beat appears the cycle after the request or previous beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            raddr_q   <= 32'd0;
            rlen_q    <= 8'd0;
            rbeat_q   <= 8'd0;
            rburst_q  <= 2'b00;
            rcnt_q    <= 3'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= 4'd0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arvalid) begin
                        raddr_q   <= araddr;
                        rlen_q    <= arlen;
                        rburst_q  <= arburst;
                        rbeat_q   <= 8'd0;
                        rid_q     <= arid;
                        arready_q <= 1'b0;
                        if (delay_w == 3'd0) begin
                            rstate_q <= R_DATA;
                            rvalid_q <= 1'b1;
                            rlast_q  <= rfetch_last;
                            rdata_q  <= rfetch_data;
                            rresp_q  <= rfetch_err ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            rstate_q <= R_WAIT;
                            rcnt_q   <= delay_w - 3'd1;
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == 3'd0) begin
                        rstate_q <= R_DATA;
                        rvalid_q <= 1'b1;
                        rlast_q  <= rfetch_last;
                        rdata_q  <= rfetch_data;
                        rresp_q  <= rfetch_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        rcnt_q <= rcnt_q - 3'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rstate_q  <= R_IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                            arready_q <= 1'b1;
                        end else begin
                            raddr_q <= rfetch_addr;
                            rbeat_q <= rbeat_q + 8'd1;
                            if (delay_w == 3'd0) begin
                                rlast_q <= rfetch_last;
                                rdata_q <= rfetch_data;
                                rresp_q <= rfetch_err ? RESP_SLVERR : RESP_OKAY;
                            end else begin
                                rstate_q <= R_WAIT;
                                rvalid_q <= 1'b0;
                                rcnt_q   <= delay_w - 3'd1;
                            end
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    wr_state_e   wstate_q;
    logic [31:0] waddr_q;
    logic [7:0]  wlen_q;
    logic [7:0]  wbeat_q;
    logic [1:0]  wburst_q;
    logic [2:0]  wcnt_q;
    logic        werr_q;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  bid_q;

    logic        wbeat_err;
    logic        wlast_err;
    logic        werr_d;
    logic        mem_we;

    // Per-beat error terms: bad address/burst blocks the store, while a wlast
    // that disagrees with awlen only taints the final response.
    always_comb begin
        wbeat_err = wburst_q[1] | ~addr_ok(waddr_q);
        wlast_err = wlast ? (wbeat_q != wlen_q) : (wbeat_q == wlen_q);
        werr_d    = werr_q | wbeat_err | wlast_err;
        mem_we    = (wstate_q == W_DATA) & wvalid & ~wbeat_err;
    end

    // Byte-lane store; never cleared, and held off while reset is asserted so
    // an aborted burst leaves no further footprint.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Write FSM with registered channel outputs; a zero wait skips W_WAIT so
    // bvalid appears the cycle after the wlast beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            waddr_q   <= 32'd0;
            wlen_q    <= 8'd0;
            wbeat_q   <= 8'd0;
            wburst_q  <= 2'b00;
            wcnt_q    <= 3'd0;
            werr_q    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= 4'd0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (awvalid) begin
                        waddr_q   <= awaddr;
                        wlen_q    <= awlen;
                        wburst_q  <= awburst;
                        wbeat_q   <= 8'd0;
                        werr_q    <= 1'b0;
                        bid_q     <= awid;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        waddr_q <= next_addr(waddr_q, wburst_q);
                        wbeat_q <= wbeat_q + 8'd1;
                        werr_q  <= werr_d;
                        if (wlast) begin
                            wready_q <= 1'b0;
                            if (delay_w == 3'd0) begin
                                wstate_q <= W_RESP;
                                bvalid_q <= 1'b1;
                                bresp_q  <= werr_d ? RESP_SLVERR : RESP_OKAY;
                            end else begin
                                wstate_q <= W_WAIT;
                                wcnt_q   <= delay_w - 3'd1;
                            end
                        end
                    end
                end
                W_WAIT: begin
                    if (wcnt_q == 3'd0) begin
                        wstate_q <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= werr_q ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_axi_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25040111_axi_mem_resp
//  Brief    : Directed and randomized AXI traffic against a word-array
//             reference model of the memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_axi_mem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LIM   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        rvalid, rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bvalid, bready = 1'b1;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wd [32];
    logic [3:0]  ws [32];

    always #5 clk = ~clk;

    ysyx_25040111_axi_mem_resp dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat);
`ifdef YSYX_25040111_AXI_DELAY_EN
        check(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
        check(tag, 32'(lat), 32'd1);
`endif
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int k);
        return (burst == 2'b00) ? a : a + 32'(4 * k);
    endfunction

    // Full write transaction; wlast is driven on beat last_at (normally len).
    task automatic axi_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int last_at);
        logic        err;
        logic [31:0] ba;
        logic [31:0] w;
        int          lat;
        err = burst[1] || (last_at != int'(len));
        awaddr = a; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        for (int k = 0; k < LIM && !awready; k++) begin @(posedge clk); #1; end
        if (!awready) check("aw_ready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
            for (int k = 0; k < LIM && !wready; k++) begin @(posedge clk); #1; end
            if (!wready) check("w_ready", 32'(wready), 32'd1);
            @(posedge clk);
            ba = beat_addr(a, burst, i);
            if (!burst[1] && in_rng(ba)) begin
                w = model[(ba - BASE) >> 2];
                for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                model[(ba - BASE) >> 2] = w;
            end else begin
                err = 1'b1;
            end
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        lat = 1;
        while (!bvalid && lat < LIM) begin @(posedge clk); #1; lat++; end
        check("bvalid", 32'(bvalid), 32'd1);
        check_lat("b_lat", lat);
        check("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
        check("bid", 32'(bid), 32'(id));
        @(posedge clk); #1;
        check("b_done", 32'(bvalid), 32'd0);
    endtask

    // Full read transaction; expected beats are snapshotted from the model
    // before the request is issued.
    task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_beat, input int stall_cyc);
        logic [31:0] ed [16];
        logic [1:0]  er [16];
        logic [31:0] ba;
        int          lat;
        for (int k = 0; k <= int'(len); k++) begin
            ba = beat_addr(a, burst, k);
            if (!burst[1] && in_rng(ba)) begin ed[k] = model[(ba - BASE) >> 2]; er[k] = 2'b00; end
            else begin ed[k] = 32'd0; er[k] = 2'b10; end
        end
        araddr = a; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        for (int k = 0; k < LIM && !arready; k++) begin @(posedge clk); #1; end
        if (!arready) check("ar_ready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            lat = 1;
            while (!rvalid && lat < LIM) begin @(posedge clk); #1; lat++; end
            check("rvalid", 32'(rvalid), 32'd1);
            check_lat("r_lat", lat);
            check("rdata", rdata, ed[k]);
            check("rresp", 32'(rresp), 32'(er[k]));
            check("rlast", 32'(rlast), 32'(k == int'(len)));
            check("rid", 32'(rid), 32'(id));
            if (k == stall_beat && stall_cyc > 0) begin
                rready = 1'b0;
                repeat (stall_cyc) @(posedge clk);
                #1;
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_data", rdata, ed[k]);
                check("r_hold_last", 32'(rlast), 32'(k == int'(len)));
                rready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("r_done", 32'(rvalid), 32'd0);
    endtask

    task automatic fill_wd(input logic [3:0] strb);
        for (int i = 0; i < 32; i++) begin
            wd[i] = $urandom;
            ws[i] = (strb == 4'd0) ? 4'($urandom_range(0, 15)) : strb;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          last_at;

        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rlast",   32'(rlast),   32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rid",     32'(rid),     32'd0);
        check("rst_bid",     32'(bid),     32'd0);
        rst = 1'b0;

        // Give words 0..15 defined contents.
        fill_wd(4'hF);
        axi_write(BASE, 4'd1, 8'd15, 2'b01, 15);

        // Full-word write then read back.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(32'h8000_0010, 4'd2, 8'd0, 2'b01, 0);
        axi_read(32'h8000_0010, 4'd3, 8'd0, 2'b01, -1, 0);

        // Single-lane update.
        wd[0] = 32'h0000_5500; ws[0] = 4'b0010;
        axi_write(32'h8000_0010, 4'd4, 8'd0, 2'b01, 0);
        axi_read(32'h8000_0010, 4'd5, 8'd0, 2'b01, -1, 0);

        // INCR burst with a two-cycle stall on the first beat.
        axi_read(BASE, 4'd9, 8'd3, 2'b01, 0, 2);

        // Out-of-range and WRAP/reserved bursts.
        axi_read(32'h7FFF_FFFC, 4'd6, 8'd0, 2'b01, -1, 0);
        axi_read(BASE + 32'h1000, 4'd6, 8'd1, 2'b01, -1, 0);
        axi_read(BASE + 32'h0FFC, 4'd7, 8'd1, 2'b01, -1, 0);
        fill_wd(4'hF);
        axi_write(32'h8000_0020, 4'd7, 8'd1, 2'b10, 1);
        axi_read(32'h8000_0020, 4'd8, 8'd1, 2'b01, -1, 0);
        axi_read(32'h8000_0020, 4'd8, 8'd1, 2'b11, -1, 0);
        axi_write(32'h7FFF_FFF8, 4'd3, 8'd0, 2'b01, 0);

        // FIXED bursts.
        fill_wd(4'hF);
        axi_write(32'h8000_0030, 4'd10, 8'd2, 2'b00, 2);
        axi_read(32'h8000_0030, 4'd11, 8'd1, 2'b00, 1, 1);

        // wlast early and late.
        fill_wd(4'hF);
        axi_write(32'h8000_0000, 4'd12, 8'd3, 2'b01, 1);
        fill_wd(4'hF);
        axi_write(32'h8000_0020, 4'd13, 8'd1, 2'b01, 2);
        axi_read(32'h8000_0000, 4'd14, 8'd11, 2'b01, -1, 0);

`ifndef YSYX_25040111_AXI_DELAY_EN
        // Simultaneous AR/AW on one word, then AR aligned with the W beat.
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        fork
            axi_write(32'h8000_0008, 4'd1, 8'd0, 2'b01, 0);
            axi_read(32'h8000_0008, 4'd2, 8'd0, 2'b01, -1, 0);
        join
        axi_read(32'h8000_0008, 4'd3, 8'd0, 2'b01, -1, 0);
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        fork
            axi_write(32'h8000_0008, 4'd4, 8'd0, 2'b01, 0);
            begin @(posedge clk); #1; axi_read(32'h8000_0008, 4'd5, 8'd0, 2'b01, -1, 0); end
        join
        axi_read(32'h8000_0008, 4'd6, 8'd0, 2'b01, -1, 0);
`endif

        // Reset asserted while beat 2 of a 4-beat write is being offered.
        fill_wd(4'hF);
        awaddr = 32'h8000_0010; awid = 4'd8; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = wd[0]; wstrb = 4'hF; wlast = 1'b0;
        @(posedge clk);
        model[4] = wd[0];
        #1;
        wdata = wd[1]; rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_awready", 32'(awready), 32'd1);
        check("rstmid_wready",  32'(wready),  32'd0);
        rst = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstmid_bvalid", 32'(bvalid), 32'd0);
        end
        axi_read(32'h8000_0010, 4'd9, 8'd1, 2'b01, -1, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            len = 8'($urandom_range(0, 3));
            a   = BASE + 32'(4 * $urandom_range(0, 12));
            case ($urandom_range(0, 9))
                0:       burst = 2'b00;
                1:       burst = 2'b10;
                default: burst = 2'b01;
            endcase
            if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
            if ($urandom_range(0, 1) == 0) begin
                fill_wd(4'd0);
                last_at = int'(len);
                if ($urandom_range(0, 7) == 0) last_at = int'(len) + 1;
                else if ($urandom_range(0, 7) == 0 && len != 8'd0) last_at = int'(len) - 1;
                axi_write(a, 4'($urandom_range(0, 15)), len, burst, last_at);
            end else begin
                axi_read(a, 4'($urandom_range(0, 15)), len, burst,
                         $urandom_range(0, 3), $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
